// File: rtl/scan_mux_pkg.sv
// Shared types and encodings for the scanning channel multiplexer.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_n_to_1.sv
// Index-to-data selector. An index with no matching channel yields zero
// data and o_hit low, so non-power-of-two channel counts are safe.
module mux_n_to_1
    import scan_mux_pkg::*;
#(
    parameter  int WIDTH    = 1,
    parameter  int CHANNELS = 32,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic [SELW-1:0]           i_sel,
    output logic [WIDTH-1:0]          o_data,
    output logic                      o_hit
);

    // Compare against every real channel; unmatched indices fall through to zero.
    always_comb begin
        o_data = '0;
        o_hit  = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (i_sel == SELW'(k)) begin
                o_data = i_data[k*WIDTH +: WIDTH];
                o_hit  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_mux.sv
// Channel multiplexer with manual selection and a dwell-timed scan mode.
// Outputs are registered; the mux is driven with the index that will be
// current after the edge, so out_sel always names the channel behind out.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter  int WIDTH    = 1,
    parameter  int CHANNELS = 32,
    parameter  int DWELL    = 4,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in,
    input  logic [SELW-1:0]           select,
    input  logic                      mode,
    input  logic                      enable,
    output logic [WIDTH-1:0]          out,
    output logic [SELW-1:0]           out_sel,
    output logic                      out_valid,
    output logic                      wrap
);

    localparam int              DW      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SELW-1:0] LAST_CH = SELW'(CHANNELS - 1);
    localparam logic [DW-1:0]   LAST_DW = DW'(DWELL - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [SELW-1:0]   r_ptr;
    logic [DW-1:0]     r_dwell;
    logic [WIDTH-1:0]  r_out;
    logic [SELW-1:0]   r_out_sel;
    logic              r_out_valid;
    logic              r_wrap;

    logic [SELW-1:0]   w_ptr_nxt;
    logic [DW-1:0]     w_dwell_nxt;
    logic [SELW-1:0]   w_idx;
    logic              w_wrap_nxt;
    logic [WIDTH-1:0]  w_mux_data;
    logic              w_mux_hit;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state depends only on the controls, from any state.
    always_comb begin
        w_state_nxt = IDLE;
        if (enable) w_state_nxt = (mode == MODE_SCAN) ? SCAN : MANUAL;
    end

    // Scan pointer / dwell sequencing and the mux index for this edge.
    always_comb begin
        w_ptr_nxt   = r_ptr;
        w_dwell_nxt = r_dwell;
        w_idx       = select;
        w_wrap_nxt  = 1'b0;
        case (w_state_nxt)
            SCAN: begin
                if (r_state != SCAN) begin
                    // Entry: start at select; an out-of-range select starts at 0
                    // so the pointer never sits on a non-existent channel.
                    w_ptr_nxt   = (select <= LAST_CH) ? select : '0;
                    w_dwell_nxt = '0;
                end else if (r_dwell == LAST_DW) begin
                    w_dwell_nxt = '0;
                    w_wrap_nxt  = (r_ptr >= LAST_CH);
                    w_ptr_nxt   = (r_ptr >= LAST_CH) ? '0 : r_ptr + SELW'(1);
                end else begin
                    w_dwell_nxt = r_dwell + DW'(1);
                end
                w_idx = w_ptr_nxt;
            end
            MANUAL:  w_dwell_nxt = '0;
            default: ;
        endcase
    end

    mux_n_to_1 #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) u_mux (
        .i_data (in),
        .i_sel  (w_idx),
        .o_data (w_mux_data),
        .o_hit  (w_mux_hit)
    );

    // Datapath registers; going idle keeps out/out_sel but drops valid and wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= '0;
            r_dwell     <= '0;
            r_out       <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_dwell <= w_dwell_nxt;
            if (w_state_nxt == IDLE) begin
                r_out_valid <= 1'b0;
                r_wrap      <= 1'b0;
            end else begin
                r_out       <= w_mux_data;
                r_out_sel   <= w_idx;
                r_out_valid <= w_mux_hit;
                r_wrap      <= w_wrap_nxt;
            end
        end
    end

    assign out       = r_out;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_scan_mux.sv
// Scoreboard bench for scan_mux: three instances (32ch/dwell 4, 5ch/dwell 1,
// 32ch/dwell 1). Stimulus pushes hand-computed expectations, a monitor pops
// and compares on the falling edge.
module tb_scan_mux;

    typedef struct {
        logic [7:0]  d;
        logic [7:0]  s;
        logic        v;
        logic        w;
        logic [95:0] tag;
    } exp_t;

    logic clk;
    logic rst;

    // A: 32 channels, dwell 4
    logic [32*8-1:0] a_in;
    logic [4:0]      a_sel, a_osel;
    logic            a_md, a_en, a_vld, a_wrap;
    logic [7:0]      a_out;
    // B: 5 channels, dwell 1
    logic [5*8-1:0]  b_in;
    logic [2:0]      b_sel, b_osel;
    logic            b_md, b_en, b_vld, b_wrap;
    logic [7:0]      b_out;
    // C: 32 channels, dwell 1
    logic [32*8-1:0] c_in;
    logic [4:0]      c_sel, c_osel;
    logic            c_md, c_en, c_vld, c_wrap;
    logic [7:0]      c_out;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    int   n_chk;
    int   n_fail;

    scan_mux #(.WIDTH(8), .CHANNELS(32), .DWELL(4)) dut_a (
        .clk(clk), .reset(rst), .in(a_in), .select(a_sel), .mode(a_md),
        .enable(a_en), .out(a_out), .out_sel(a_osel), .out_valid(a_vld), .wrap(a_wrap)
    );
    scan_mux #(.WIDTH(8), .CHANNELS(5), .DWELL(1)) dut_b (
        .clk(clk), .reset(rst), .in(b_in), .select(b_sel), .mode(b_md),
        .enable(b_en), .out(b_out), .out_sel(b_osel), .out_valid(b_vld), .wrap(b_wrap)
    );
    scan_mux #(.WIDTH(8), .CHANNELS(32), .DWELL(1)) dut_c (
        .clk(clk), .reset(rst), .in(c_in), .select(c_sel), .mode(c_md),
        .enable(c_en), .out(c_out), .out_sel(c_osel), .out_valid(c_vld), .wrap(c_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input exp_t e, input logic [7:0] d, input logic [7:0] s,
                         input logic v, input logic w);
        n_chk++;
        if ({d, s, v, w} !== {e.d, e.s, e.v, e.w}) begin
            n_fail++;
            $display("FAIL %0s: got out=%h sel=%0d vld=%b wrap=%b, want out=%h sel=%0d vld=%b wrap=%b",
                     e.tag, d, s, v, w, e.d, e.s, e.v, e.w);
        end
    endtask

    // Monitor: one popped expectation per instance per cycle when present.
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() != 0) begin
            e = qa.pop_front();
            check(e, a_out, {3'b0, a_osel}, a_vld, a_wrap);
        end
        if (qb.size() != 0) begin
            e = qb.pop_front();
            check(e, b_out, {5'b0, b_osel}, b_vld, b_wrap);
        end
        if (qc.size() != 0) begin
            e = qc.pop_front();
            check(e, c_out, {3'b0, c_osel}, c_vld, c_wrap);
        end
    end

    task automatic push(input int dut, input logic [7:0] ed, input logic [7:0] es,
                        input logic ev, input logic ew, input logic [95:0] tag);
        exp_t e;
        e.d = ed; e.s = es; e.v = ev; e.w = ew; e.tag = tag;
        case (dut)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    // Apply controls to one instance, clock once, record what should appear.
    task automatic step(input int dut, input logic en, input logic md, input logic [7:0] sel,
                        input logic [7:0] ed, input logic [7:0] es, input logic ev,
                        input logic ew, input logic [95:0] tag);
        case (dut)
            0:       begin a_en = en; a_md = md; a_sel = sel[4:0]; end
            1:       begin b_en = en; b_md = md; b_sel = sel[2:0]; end
            default: begin c_en = en; c_md = md; c_sel = sel[4:0]; end
        endcase
        @(posedge clk);
        push(dut, ed, es, ev, ew, tag);
        @(negedge clk);
    endtask

    initial begin
        int p;
        n_chk = 0; n_fail = 0;
        rst = 1'b1;
        a_en = 0; a_md = 0; a_sel = 0;
        b_en = 0; b_md = 0; b_sel = 0;
        c_en = 0; c_md = 0; c_sel = 0;
        for (int k = 0; k < 32; k++) begin
            a_in[k*8 +: 8] = 8'(k + 'h40);
            c_in[k*8 +: 8] = 8'(k + 'h40);
        end
        for (int k = 0; k < 5; k++) b_in[k*8 +: 8] = 8'(k + 'h40);

        // Reset state on all instances.
        repeat (2) @(posedge clk);
        push(0, 8'h00, 8'd0, 1'b0, 1'b0, "rst_a");
        push(1, 8'h00, 8'd0, 1'b0, 1'b0, "rst_b");
        push(2, 8'h00, 8'd0, 1'b0, 1'b0, "rst_c");
        @(negedge clk);
        rst = 1'b0;

        // A: manual selection, one-cycle latency.
        step(0, 1, 0, 8'd5, 8'h45, 8'd5, 1, 0, "man5_a");
        step(0, 1, 0, 8'd7, 8'h47, 8'd7, 1, 0, "man7_a");

        // A: scan from 30, dwell 4, wrap to 0; select change mid-scan ignored.
        for (int i = 0; i < 50; i++) begin
            p = (i < 4) ? 30 : (i < 8) ? 31 : (i - 8) / 4;
            step(0, 1, 1, (i >= 5) ? 8'd12 : 8'd30, 8'(p + 'h40), 8'(p), 1, i == 8, "scan_a");
        end

        // A: disabled while at pointer 10 -> hold, not valid.
        repeat (3) step(0, 0, 1, 8'd12, 8'h4A, 8'd10, 0, 0, "hold_a");

        // A: re-enable scan -> restarts at current select with dwell cleared.
        for (int i = 0; i < 5; i++) begin
            p = (i < 4) ? 12 : 13;
            step(0, 1, 1, 8'd12, 8'(p + 'h40), 8'(p), 1, 0, "restart_a");
        end

        // A: asynchronous reset mid-cycle clears outputs before the next rising edge.
        @(posedge clk);
        #1 rst = 1'b1;
        push(0, 8'h00, 8'd0, 1'b0, 1'b0, "async_rst_a");
        @(negedge clk);
        rst = 1'b0;

        // A: first edge after release enters scan from IDLE; out tracks live data.
        step(0, 1, 1, 8'd20, 8'h54, 8'd20, 1, 0, "rel_a");
        a_in[20*8 +: 8] = 8'hAA;
        step(0, 1, 1, 8'd20, 8'hAA, 8'd20, 1, 0, "live_a");
        a_in[20*8 +: 8] = 8'h54;
        step(0, 1, 0, 8'd3, 8'h43, 8'd3, 1, 0, "s2m_a");
        step(0, 1, 1, 8'd3, 8'h43, 8'd3, 1, 0, "m2s_a");
        step(0, 1, 1, 8'd3, 8'h43, 8'd3, 1, 0, "dwell_a");

        // B: 5 channels, out-of-range index and scan wrap 4 -> 0.
        step(1, 1, 0, 8'd6, 8'h00, 8'd6, 0, 0, "oob_b");
        step(1, 1, 0, 8'd4, 8'h44, 8'd4, 1, 0, "man4_b");
        step(1, 1, 1, 8'd3, 8'h43, 8'd3, 1, 0, "scan3_b");
        step(1, 1, 1, 8'd3, 8'h44, 8'd4, 1, 0, "scan4_b");
        step(1, 1, 1, 8'd3, 8'h40, 8'd0, 1, 1, "wrap_b");
        step(1, 1, 1, 8'd3, 8'h41, 8'd1, 1, 0, "scan1_b");
        step(1, 1, 1, 8'd3, 8'h42, 8'd2, 1, 0, "scan2_b");
        step(1, 0, 1, 8'd3, 8'h42, 8'd2, 0, 0, "hold_b");
        step(1, 1, 0, 8'd7, 8'h00, 8'd7, 0, 0, "oob7_b");

        // C: dwell 1, mode toggling scan/manual/scan, wrap at 31.
        step(2, 1, 1, 8'd8,  8'h48, 8'd8,  1, 0, "ent_c");
        step(2, 1, 1, 8'd8,  8'h49, 8'd9,  1, 0, "adv_c");
        step(2, 1, 0, 8'd8,  8'h48, 8'd8,  1, 0, "man_c");
        step(2, 1, 1, 8'd8,  8'h48, 8'd8,  1, 0, "reent_c");
        step(2, 1, 1, 8'd8,  8'h49, 8'd9,  1, 0, "adv9_c");
        step(2, 1, 1, 8'd8,  8'h4A, 8'd10, 1, 0, "adv10_c");
        step(2, 1, 0, 8'd31, 8'h5F, 8'd31, 1, 0, "man31_c");
        step(2, 1, 1, 8'd31, 8'h5F, 8'd31, 1, 0, "ent31_c");
        step(2, 1, 1, 8'd31, 8'h40, 8'd0,  1, 1, "wrap_c");
        step(2, 1, 1, 8'd31, 8'h41, 8'd1,  1, 0, "post_c");
        step(2, 0, 1, 8'd31, 8'h41, 8'd1,  0, 0, "hold_c");

        @(posedge clk);
        n_chk++;
        if (qa.size() + qb.size() + qc.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0",
                     qa.size() + qb.size() + qc.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 Parameter WIDTH, default 1, bit width of each data channel.
REQ-002 Parameter CHANNELS, default 32, number of input channels (>=2, need not be a power of two).
REQ-003 Parameter DWELL, default 4, cycles spent on each channel in scan mode (>=1).
REQ-004 Local SELW = $clog2(CHANNELS).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in  input  CHANNELS*WIDTH  packed channels; channel k = in[k*WIDTH +: WIDTH].
REQ-008 select  input  SELW  manual channel index; scan start index.
REQ-009 mode  input  1  0 = manual, 1 = scan.
REQ-010 enable  input  1  1 = operate, 0 = hold.
REQ-011 out  output  WIDTH  registered selected data.
REQ-012 out_sel  output  SELW  channel index that produced out.
REQ-013 out_valid  output  1  out/out_sel valid this cycle.
REQ-014 wrap  output  1  one-cycle pulse when scan pointer wraps CHANNELS-1 -> 0.

Function
REQ-015 FSM states IDLE, MANUAL, SCAN; state registered.
REQ-016 Any state, enable=0 -> IDLE next cycle; enable=1 & mode=0 -> MANUAL; enable=1 & mode=1 -> SCAN.
REQ-017 IDLE: out and out_sel hold last values; out_valid=0; wrap=0; dwell counter and scan pointer hold.
REQ-018 MANUAL: each enabled cycle registers out <= channel[select], out_sel <= select, out_valid <= 1; latency exactly 1 cycle from select/in to out.
REQ-019 Entry into SCAN from IDLE or MANUAL: pointer loads select, dwell counter clears to 0, out <= channel[select] on that same edge.
REQ-020 In SCAN: dwell counter increments each cycle; at DWELL-1 it clears and pointer advances by 1 on that edge.
REQ-021 Pointer at CHANNELS-1 advancing -> 0, and wrap=1 in the following cycle only; no other wrap pulse.
REQ-022 In SCAN: out <= channel[pointer], out_sel <= pointer, out_valid <= 1 every cycle; out follows live in data (not sampled once per dwell).
REQ-023 DWELL=1: pointer advances every cycle.
REQ-024 Index >= CHANNELS (non-power-of-two CHANNELS): out <= 0, out_sel <= index, out_valid <= 0; scan pointer never reaches such an index.
REQ-025 mode change while enabled takes effect on the next edge; no idle cycle inserted; SCAN->MANUAL discards dwell count.
REQ-026 select changes in SCAN are ignored until the next SCAN entry.

Reset
REQ-027 reset=1 forces immediately, without clk: state=IDLE, out=0, out_sel=0, out_valid=0, wrap=0, pointer=0, dwell counter=0.
REQ-028 Reset mid-scan discards pointer and dwell count; first edge after release follows REQ-016 from IDLE.

Structure
REQ-029 Package scan_mux_pkg holds the state enum (IDLE, MANUAL, SCAN) and mode encoding constants MODE_MANUAL=0, MODE_SCAN=1.
REQ-030 One combinational sub-module mux_n_to_1 (parameters WIDTH, CHANNELS) performs index-to-data selection, including the REQ-024 zero output; scan_mux instantiates it once.

Verification
REQ-031 WIDTH=8, CHANNELS=32, in[k]=k+0x40; reset, enable=1, mode=0, select=5 -> out=0x45, out_sel=5, out_valid=1 one cycle later.
REQ-032 DWELL=4, mode=1, select=30 -> out_sel 30 for 4 cycles, 31 for 4, then 0 with wrap=1 for exactly one cycle.
REQ-033 CHANNELS=5, manual select=6 -> out=0, out_valid=0; scan from 3 -> sequence 3,4,0,1 with wrap after 4.
REQ-034 Scanning at pointer 10, enable=0 for 3 cycles -> out_valid=0, out/out_sel hold; enable=1, mode=1 -> restarts at current select, dwell cleared.
REQ-035 Assert reset asynchronously mid-cycle during scan -> all outputs 0 before next clk edge; release -> IDLE behaviour.
REQ-036 DWELL=1, mode toggled 1->0->1 on consecutive cycles -> out_sel advances each scan cycle, manual cycle shows select, scan reloads select.
